// File: rtl/rr_grant_arbiter_pkg.sv
// Shared types and helpers for the round-robin grant arbiter (package arb_pkg).
// Indices wider than ARB_MAX_REQ requesters are outside the helper's range.
package arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_HOLD
    } arb_state_e;

    localparam int ARB_MAX_REQ = 256;

    function automatic int arb_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // OR of set-bit positions; exact for a one-hot or all-zero input.
    function automatic int onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < ARB_MAX_REQ; i++) begin
            if (oh[i]) idx |= i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_grant_arbiter_if
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = arb_idx_w(NUM_REQ)
);
    logic               en;
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] lock;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_valid;
    logic               req_up;

    modport master (output en, req, lock, input gnt, gnt_idx, gnt_valid, req_up);
    modport slave  (input en, req, lock, output gnt, gnt_idx, gnt_valid, req_up);
endinterface

// File: rtl/rr_grant_arbiter_pick.sv
// rr_pick: combinational lowest-index pick among requests strictly above ptr,
// wrapping to the lowest request overall when none lie above it.
module rr_pick
    import arb_pkg::*;
#(
    parameter int NUM_REQ = 16,
    parameter int IDX_W   = arb_idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [IDX_W-1:0]   pick_idx,
    output logic               pick_valid
);
    logic [NUM_REQ-1:0] mask;
    logic [NUM_REQ-1:0] req_m;
    logic [NUM_REQ-1:0] sel;

    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask[i] = (i > int'(ptr));
        end
    end

    assign req_m      = req & mask;
    assign sel        = (|req_m) ? req_m : req;
    // x & -x isolates the lowest set bit
    assign pick       = sel & (~sel + NUM_REQ'(1));
    assign pick_idx   = IDX_W'(onehot_to_idx(ARB_MAX_REQ'(pick)));
    assign pick_valid = |req;
endmodule

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter with owner lock. Optional ARB_HOLD_LIMIT_EN
// caps consecutive owned cycles at MAX_HOLD while others are waiting.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int NUM_REQ  = 16,
    parameter int IDX_W    = arb_idx_w(NUM_REQ),
    parameter int MAX_HOLD = 4
) (
    input logic               clock,
    input logic               reset_n,
    rr_grant_arbiter_if.slave bus
);
    localparam int HC_W = $clog2(MAX_HOLD + 1);

    arb_state_e         state;
    logic [IDX_W-1:0]   ptr;
    logic [HC_W-1:0]    hold_cnt;
    logic [NUM_REQ-1:0] gnt_q;
    logic [IDX_W-1:0]   gnt_idx_q;
    logic               gnt_valid_q;

    logic [NUM_REQ-1:0] pick;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;
    logic               limit_hit;
    logic               owner_keep;

    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req       (bus.req),
        .ptr       (ptr),
        .pick      (pick),
        .pick_idx  (pick_idx),
        .pick_valid(pick_valid)
    );

`ifdef ARB_HOLD_LIMIT_EN
    // Forcing the owner out only matters when someone else is waiting.
    assign limit_hit = (hold_cnt == HC_W'(MAX_HOLD)) && (|(bus.req & ~gnt_q));
`else
    assign limit_hit = 1'b0;
`endif

    assign owner_keep = (state != ARB_IDLE) && bus.req[gnt_idx_q]
                        && bus.lock[gnt_idx_q] && !limit_hit;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ARB_IDLE;
            ptr         <= IDX_W'(NUM_REQ - 1);
            hold_cnt    <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else if (!bus.en) begin
            state       <= ARB_IDLE;
            hold_cnt    <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else if (owner_keep) begin
            state <= ARB_HOLD;
            if (hold_cnt != HC_W'(MAX_HOLD)) hold_cnt <= hold_cnt + HC_W'(1);
        end else if (pick_valid) begin
            state       <= ARB_GRANT;
            ptr         <= pick_idx;
            hold_cnt    <= HC_W'(1);
            gnt_q       <= pick;
            gnt_idx_q   <= pick_idx;
            gnt_valid_q <= 1'b1;
        end else begin
            state       <= ARB_IDLE;
            hold_cnt    <= '0;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.req_up    = (|bus.req) & bus.en;
endmodule
